// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative, valid/ready handshaked AES SubBytes stage.
// LANES combinational S-box lanes walk the 16 state bytes, one group per
// cycle, so a block takes ROUNDS = 16/LANES cycles. The output register
// doubles as the working register.
// Build option: define SUB_BYTES_INV_SBOX_EN to add inverse S-box tables
// selected per block by in_inv; without it only forward SubBytes is built.
module sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int ROUNDS = 16 / LANES;
   localparam int CNT_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
         $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   // Forward S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] f_sbox_fwd(input logic [7:0] b);
      return SBOX_FWD[{~b, 3'b000} +: 8];
   endfunction

`ifdef SUB_BYTES_INV_SBOX_EN
   // Inverse S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] f_sbox_inv(input logic [7:0] b);
      return SBOX_INV[{~b, 3'b000} +: 8];
   endfunction
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [127:0]     r_data;
   logic             r_mode;
   logic             r_out_valid;
   logic             r_busy;

   logic [3:0]       w_grp_base;
   logic [7:0]       w_lane_in [LANES];
   logic [7:0]       w_sub     [LANES];
   logic [127:0]     w_next_data;

   // Ready is combinational from out_ready only, never from in_valid.
   assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ready);
   assign out_valid = r_out_valid;
   assign out_data  = r_data;
   assign busy      = r_busy;

   // First byte index of the group handled this cycle.
   assign w_grp_base = 4'(32'(r_cnt) * LANES);

   genvar l;
   generate
      for (l = 0; l < LANES; l++) begin : g_lane
         assign w_lane_in[l] = r_data[{w_grp_base + 4'(l), 3'b000} +: 8];
`ifdef SUB_BYTES_INV_SBOX_EN
         assign w_sub[l] = r_mode ? f_sbox_inv(w_lane_in[l]) : f_sbox_fwd(w_lane_in[l]);
`else
         assign w_sub[l] = f_sbox_fwd(w_lane_in[l]);
`endif
      end
   endgenerate

`ifndef SUB_BYTES_INV_SBOX_EN
   // Forward-only build: the mode input and stored mode have no effect.
   logic w_unused_mode;
   assign w_unused_mode = in_inv ^ r_mode;
`endif

   // Each byte takes its lane result when its group is active, else holds.
   genvar b;
   generate
      for (b = 0; b < 16; b++) begin : g_byte
         localparam int B_GRP  = b / LANES;
         localparam int B_LANE = b % LANES;
         assign w_next_data[b*8 +: 8] = (r_cnt == CNT_W'(B_GRP)) ? w_sub[B_LANE]
                                                               : r_data[b*8 +: 8];
      end
   endgenerate

   // Control FSM: block load, group iteration and output hold/handoff.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_data      <= 128'h0;
         r_mode      <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_data      <= in_data;
`ifdef SUB_BYTES_INV_SBOX_EN
                  r_mode      <= in_inv;
`else
                  r_mode      <= 1'b0;
`endif
                  r_cnt       <= '0;
                  r_state     <= ST_RUN;
                  r_busy      <= 1'b1;
                  r_out_valid <= 1'b0;
               end else begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            ST_RUN: begin
               r_data <= w_next_data;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state     <= ST_HOLD;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
               end else begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  if (in_valid) begin
                     // Handoff: result leaves and the next block loads now.
                     r_data      <= in_data;
`ifdef SUB_BYTES_INV_SBOX_EN
                     r_mode      <= in_inv;
`else
                     r_mode      <= 1'b0;
`endif
                     r_cnt       <= '0;
                     r_state     <= ST_RUN;
                     r_busy      <= 1'b1;
                     r_out_valid <= 1'b0;
                  end else begin
                     r_state     <= ST_IDLE;
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b0;
                  end
               end else begin
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cnt       <= '0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: LANES=4 main instance plus LANES=1 and
// LANES=16 instances for latency checks. Expected S-box values come from
// FIPS-197 constants and a GF(2^8) inverse + affine reference model.
module tb_sub_bytes_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] in_data;
   logic         in_inv;
   logic         out_ready;
   logic         v4, v1, v16;
   logic         rdy4, rdy1, rdy16;
   logic         ov4, ov1, ov16;
   logic         bz4, bz1, bz16;
   logic [127:0] od4, od1, od16;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [127:0] V_SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] V_SEQ_S  = 128'h637c777bf26b6fc53001672bfed7ab76;
   localparam logic [127:0] V_ALL63  = 128'h63636363636363636363636363636363;
   localparam logic [127:0] V_FWD2   = 128'hfb10f521897fa8a6047c85f1bb0e6238;
   localparam logic [127:0] V_PAIR   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] V_PAIR_S = 128'h638293c31bfc33f5c4eeacea4bc12816;

   always #5 clk = ~clk;

   sub_bytes_iter #(.LANES(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(in_data),
      .in_inv(in_inv), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .busy(bz4));

   sub_bytes_iter #(.LANES(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(in_data),
      .in_inv(in_inv), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bz1));

   sub_bytes_iter #(.LANES(16)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_data(in_data),
      .in_inv(in_inv), .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .busy(bz16));

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      if (a == 8'h00) return 8'h00;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] ref_fwd(input logic [7:0] a);
      logic [7:0] q = ginv(a);
      return q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] ref_inv(input logic [7:0] a);
      return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] ref_block(input logic [127:0] d, input logic inv);
      logic [127:0] r = 128'h0;
      for (int i = 0; i < 16; i++)
         r[i*8 +: 8] = inv ? ref_inv(d[i*8 +: 8]) : ref_fwd(d[i*8 +: 8]);
      return r;
   endfunction

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs == exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Cycles until the LANES=4 instance raises out_valid, bounded at 40.
   task automatic wait_ov4(output int cyc);
      cyc = 0;
      while (!ov4 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, busy_cnt, lat4, lat1, lat16;
      logic [127:0] d4, d1, d16, exp_v;
      logic [127:0] blk [8];
      logic         binv [8];
      logic         eff_inv;

      rst = 1'b1; in_data = 128'h0; in_inv = 1'b0; out_ready = 1'b1;
      v4 = 1'b0; v1 = 1'b0; v16 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk_bit("rst_out_valid", ov4, 1'b0);
      chk_bit("rst_busy", bz4, 1'b0);
      chk_vec("rst_out_data", od4, 128'h0);
      chk_bit("rst_in_ready", rdy4, 1'b1);

      // Test 1: zero block, latency 4, busy for 4 cycles
      in_data = 128'h0; v4 = 1'b1;
      tick();
      v4 = 1'b0;
      chk_bit("t1_ready_in_run", rdy4, 1'b0);
      busy_cnt = bz4 ? 1 : 0;
      cyc = 0;
      while (!ov4 && cyc < 40) begin
         tick();
         cyc++;
         if (bz4) busy_cnt++;
      end
      chk_int("t1_latency", cyc, 4);
      chk_int("t1_busy_cycles", busy_cnt, 4);
      chk_vec("t1_data", od4, V_ALL63);
      tick();
      chk_bit("t1_drain_valid", ov4, 1'b0);
      chk_bit("t1_drain_ready", rdy4, 1'b1);

      // Test 2: FIPS vector on LANES=4, 1 and 16 together
      in_data = V_SEQ; v4 = 1'b1; v1 = 1'b1; v16 = 1'b1;
      tick();
      v4 = 1'b0; v1 = 1'b0; v16 = 1'b0;
      lat4 = 0; lat1 = 0; lat16 = 0;
      d4 = 128'h0; d1 = 128'h0; d16 = 128'h0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (ov4 && lat4 == 0) begin lat4 = c; d4 = od4; end
         if (ov1 && lat1 == 0) begin lat1 = c; d1 = od1; end
         if (ov16 && lat16 == 0) begin lat16 = c; d16 = od16; end
      end
      chk_int("t2_lat_l4", lat4, 4);
      chk_vec("t2_data_l4", d4, V_SEQ_S);
      chk_int("t2_lat_l1", lat1, 16);
      chk_vec("t2_data_l1", d1, V_SEQ_S);
      chk_int("t2_lat_l16", lat16, 1);
      chk_vec("t2_data_l16", d16, V_SEQ_S);

      // Test 3: inverse request (forward result when the option is absent)
      in_data = V_SEQ_S; in_inv = 1'b1; v4 = 1'b1;
      tick();
      v4 = 1'b0; in_inv = 1'b0;
      wait_ov4(cyc);
      chk_int("t3_latency", cyc, 4);
`ifdef SUB_BYTES_INV_SBOX_EN
      chk_vec("t3_data_inv", od4, V_SEQ);
`else
      chk_vec("t3_data_fwd", od4, V_FWD2);
`endif
      tick();

      // Test 4: backpressure for 10 cycles, then handoff
      out_ready = 1'b0; in_data = V_PAIR; v4 = 1'b1;
      tick();
      v4 = 1'b0;
      wait_ov4(cyc);
      chk_int("t4_latency", cyc, 4);
      chk_vec("t4_data", od4, V_PAIR_S);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk_bit("t4_hold_valid", ov4, 1'b1);
         chk_vec("t4_hold_data", od4, V_PAIR_S);
         chk_bit("t4_hold_ready", rdy4, 1'b0);
      end
      in_data = V_SEQ; v4 = 1'b1; out_ready = 1'b1;
      #1;
      chk_bit("t4_handoff_ready", rdy4, 1'b1);
      tick();
      v4 = 1'b0;
      chk_bit("t4_no_bubble_valid", ov4, 1'b0);
      chk_bit("t4_no_bubble_busy", bz4, 1'b1);
      wait_ov4(cyc);
      chk_int("t4_next_latency", cyc, 4);
      chk_vec("t4_next_data", od4, V_SEQ_S);
      tick();

      // Test 5: stream of 8 random blocks with continuous out_ready
      for (int k = 0; k < 8; k++) begin
         blk[k]  = {$urandom(), $urandom(), $urandom(), $urandom()};
         binv[k] = 1'($urandom_range(1, 0));
      end
      in_data = blk[0]; in_inv = binv[0]; v4 = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         if (k < 7) begin
            in_data = blk[k+1]; in_inv = binv[k+1];
         end else begin
            v4 = 1'b0;
         end
         wait_ov4(cyc);
         chk_int("t5_latency", cyc, 4);
`ifdef SUB_BYTES_INV_SBOX_EN
         eff_inv = binv[k];
`else
         eff_inv = 1'b0;
`endif
         exp_v = ref_block(blk[k], eff_inv);
         chk_vec("t5_data", od4, exp_v);
         tick();
         if (k < 7) begin
            chk_bit("t5_handoff_busy", bz4, 1'b1);
         end else begin
            chk_bit("t5_final_ready", rdy4, 1'b1);
         end
      end
      in_inv = 1'b0;

      // Test 6: reset at cnt=2 mid-RUN, then a fresh block
      in_data = V_PAIR; v4 = 1'b1;
      tick();
      v4 = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_bit("t6_rst_valid", ov4, 1'b0);
      chk_vec("t6_rst_data", od4, 128'h0);
      chk_bit("t6_rst_busy", bz4, 1'b0);
      chk_bit("t6_rst_ready", rdy4, 1'b1);
      in_data = V_SEQ; v4 = 1'b1;
      tick();
      v4 = 1'b0;
      wait_ov4(cyc);
      chk_int("t6_latency", cyc, 4);
      chk_vec("t6_data", od4, V_SEQ_S);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
